// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one single-cycle ALU among NREQ requesters over valid/ready.
//            Define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins);
//            round-robin otherwise.
// Revision : 1.0
// ============================================================================
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XLEN-1:0] req_data_a,
    input  logic [NREQ*XLEN-1:0] req_data_b,
    input  logic [NREQ*5-1:0]    req_shamt,
    input  logic [NREQ*4-1:0]    req_alu_sel,
    input  logic [NREQ-1:0]      req_b_sel,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [XLEN-1:0]      rsp_data,
    output logic                 rsp_err,
    output logic [XLEN-1:0]      alu_data_a,
    output logic [XLEN-1:0]      alu_data_b,
    output logic [4:0]           alu_shamt,
    output logic [3:0]           alu_sel,
    output logic                 alu_b_sel,
    input  logic [XLEN-1:0]      alu_result,
    output logic                 busy
);

    localparam int         c_IDX_W         = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0] c_IDLE          = 2'd0;
    localparam logic [1:0] c_EXEC          = 2'd1;
    localparam logic [1:0] c_RESP          = 2'd2;
    localparam logic [3:0] c_FIRST_ILLEGAL = 4'd12;

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_owner;
    logic [NREQ-1:0]    w_owner_oh;
    logic               w_handshake;
    logic               w_arb_en;
    logic               w_grant_vld;
    logic               w_take;
    logic [c_IDX_W-1:0] w_grant_idx;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [c_IDX_W-1:0] r_last_grant;
`endif

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        logic [c_IDX_W-1:0] w_idx;
        w_idx       = '0;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = c_IDX_W'(k);
            if (req_valid[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_idx;
            end
        end
`else
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = c_IDX_W'((int'(r_last_grant) + k) % NREQ);
            if (req_valid[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_idx;
            end
        end
`endif
    end

    assign w_handshake = (r_state == c_RESP) && rsp_ready[r_owner];
    assign w_arb_en    = rst_n && ((r_state == c_IDLE) || w_handshake);
    assign w_take      = w_arb_en && w_grant_vld;
    assign busy        = (r_state != c_IDLE);

    always_comb begin
        req_ready = '0;
        if (w_take) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        w_owner_oh          = '0;
        w_owner_oh[r_owner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_owner      <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last_grant <= c_IDX_W'(NREQ - 1);
`endif
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            alu_data_a   <= '0;
            alu_data_b   <= '0;
            alu_shamt    <= '0;
            alu_sel      <= '0;
            alu_b_sel    <= 1'b0;
        end else begin
            // Operand registers only move on a grant, so the ALU sees no toggling while idle.
            if (w_take) begin
                alu_data_a   <= req_data_a[w_grant_idx*XLEN +: XLEN];
                alu_data_b   <= req_data_b[w_grant_idx*XLEN +: XLEN];
                alu_shamt    <= req_shamt[w_grant_idx*5 +: 5];
                alu_sel      <= req_alu_sel[w_grant_idx*4 +: 4];
                alu_b_sel    <= req_b_sel[w_grant_idx];
                r_owner      <= w_grant_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
                r_last_grant <= w_grant_idx;
`endif
            end

            case (r_state)
                c_IDLE: begin
                    if (w_grant_vld) begin
                        r_state <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    if (alu_sel >= c_FIRST_ILLEGAL) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        rsp_data <= alu_result;
                        rsp_err  <= 1'b0;
                    end
                    rsp_valid <= w_owner_oh;
                    r_state   <= c_RESP;
                end
                c_RESP: begin
                    if (w_handshake) begin
                        rsp_valid <= '0;
                        r_state   <= w_grant_vld ? c_EXEC : c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Scoreboard bench for alu_arbiter: directed scenarios plus random
//            traffic against a transaction-level arbitration/ALU model.
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;

    localparam int NREQ = 2;
    localparam int XLEN = 32;

    typedef struct {
        logic [XLEN-1:0] data;
        logic            err;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*XLEN-1:0] req_data_a;
    logic [NREQ*XLEN-1:0] req_data_b;
    logic [NREQ*5-1:0]    req_shamt;
    logic [NREQ*4-1:0]    req_alu_sel;
    logic [NREQ-1:0]      req_b_sel;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [XLEN-1:0]      rsp_data;
    logic                 rsp_err;
    logic [XLEN-1:0]      alu_data_a;
    logic [XLEN-1:0]      alu_data_b;
    logic [4:0]           alu_shamt;
    logic [3:0]           alu_sel;
    logic                 alu_b_sel;
    logic [XLEN-1:0]      alu_result;
    logic                 busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // Reference model state (transaction level)
    int              m_cyc  = 0;
    bit              m_busy = 1'b0;
    int              m_owner = 0;
    int              m_gcyc = 0;
    int              m_last = NREQ - 1;
    bit              hold_vld = 1'b0;
    logic [XLEN-1:0] hold_data;
    logic            hold_err;

    int              gidx[8];
    int              gcyc[8];
    int              ng;
    int              t;
    bit              got;
    logic [NREQ-1:0] g;

    alu_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data_a(req_data_a), .req_data_b(req_data_b),
        .req_shamt(req_shamt), .req_alu_sel(req_alu_sel), .req_b_sel(req_b_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_data_a(alu_data_a), .alu_data_b(alu_data_b), .alu_shamt(alu_shamt),
        .alu_sel(alu_sel), .alu_b_sel(alu_b_sel),
        .alu_result(alu_result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0 add,1 sub,2 sll,3 slt,4 sltu,5 xor,6 srl,7 sra,8 or,9 and,10 pass B,11 pass A
    function automatic logic [XLEN-1:0] alu_f(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                              input logic [4:0] sh, input logic [3:0] sel, input logic bsel);
        logic [4:0]             s;
        logic signed [XLEN-1:0] sa;
        s  = bsel ? sh : b[4:0];
        sa = a;
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << s;
            4'd3:    return {31'd0, sa < $signed(b)};
            4'd4:    return {31'd0, a < b};
            4'd5:    return a ^ b;
            4'd6:    return a >> s;
            4'd7:    return sa >>> s;
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            4'd11:   return a;
            default: return a ^ 32'hDEAD_BEEF;  // junk so the arbiter must mask it
        endcase
    endfunction

    assign alu_result = alu_f(alu_data_a, alu_data_b, alu_shamt, alu_sel, alu_b_sel);

    function automatic exp_t expect_of(input int i);
        exp_t e;
        if (req_alu_sel[i*4 +: 4] >= 4'd12) begin
            e.data = '0;
            e.err  = 1'b1;
        end else begin
            e.data = alu_f(req_data_a[i*XLEN +: XLEN], req_data_b[i*XLEN +: XLEN],
                           req_shamt[i*5 +: 5], req_alu_sel[i*4 +: 4], req_b_sel[i]);
            e.err  = 1'b0;
        end
        return e;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v, input int last);
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++) if (v[k]) return k;
`else
        for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: compares every cycle against the transaction model.
    always @(negedge clk) begin
        int              w;
        bit              hs;
        logic [NREQ-1:0] exp_rv;
        exp_t            e;
        m_cyc++;
        if (!rst_n) begin
            check("rst_req_ready", 64'(req_ready), 64'(0));
            check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            check("rst_rsp_data", 64'(rsp_data), 64'(0));
            check("rst_rsp_err", 64'(rsp_err), 64'(0));
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_alu_a", 64'(alu_data_a), 64'(0));
            check("rst_alu_sel", 64'(alu_sel), 64'(0));
            m_busy   = 1'b0;
            m_last   = NREQ - 1;
            hold_vld = 1'b0;
            sb.delete();
        end else begin
            check("busy", 64'(busy), 64'(m_busy));
            exp_rv = '0;
            if (m_busy && m_cyc >= m_gcyc + 2) exp_rv[m_owner] = 1'b1;
            check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            if (hold_vld) begin
                check("hold_data", 64'(rsp_data), 64'(hold_data));
                check("hold_err", 64'(rsp_err), 64'(hold_err));
            end
            hold_vld = 1'b0;
            hs = (exp_rv != 0) && rsp_ready[m_owner];
            if (hs) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(sb.size()), 64'(1));
                end else begin
                    e = sb.pop_front();
                    check("rsp_data", 64'(rsp_data), 64'(e.data));
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                end
            end else if (exp_rv != 0) begin
                hold_vld  = 1'b1;
                hold_data = rsp_data;
                hold_err  = rsp_err;
            end
            w = (!m_busy || hs) ? pick(req_valid, m_last) : -1;
            check("req_ready", 64'(req_ready), (w >= 0) ? (64'(1) << w) : 64'(0));
            if (w >= 0) begin
                sb.push_back(expect_of(w));
                m_busy  = 1'b1;
                m_owner = w;
                m_gcyc  = m_cyc;
                m_last  = w;
            end else if (hs) begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic set_req(input int i, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [4:0] sh, input logic [3:0] sel, input logic bsel);
        req_valid[i]              = 1'b1;
        req_data_a[i*XLEN +: XLEN] = a;
        req_data_b[i*XLEN +: XLEN] = b;
        req_shamt[i*5 +: 5]        = sh;
        req_alu_sel[i*4 +: 4]      = sel;
        req_b_sel[i]               = bsel;
    endtask

    task automatic wait_grant(input int i);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (req_ready[i]) ok = 1'b1;
        end
        check("grant_seen", 64'(ok), 64'(1));
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i, input logic [XLEN-1:0] d, input logic e, input string nm);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (rsp_valid[i]) begin
                ok = 1'b1;
                check({nm, "_data"}, 64'(rsp_data), 64'(d));
                check({nm, "_err"}, 64'(rsp_err), 64'(e));
            end
        end
        check({nm, "_seen"}, 64'(ok), 64'(1));
        @(posedge clk); #1;
    endtask

    function automatic logic [XLEN-1:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data_a = '0; req_data_b = '0;
        req_shamt = '0; req_alu_sel = '0; req_b_sel = '0; rsp_ready = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request: add 5 + 7, granted in its first cycle
        rsp_ready = '1;
        set_req(0, 32'd5, 32'd7, 5'd0, 4'd0, 1'b0);
        @(negedge clk);
        check("single_ready", 64'(req_ready), 64'(2'b01));
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_rsp(0, 32'd12, 1'b0, "single");

        // Illegal opcode
        set_req(1, 32'h1234, 32'h5678, 5'd0, 4'd13, 1'b0);
        wait_grant(1);
        wait_rsp(1, 32'd0, 1'b1, "illegal");
        @(negedge clk);
        check("illegal_idle", 64'(busy), 64'(0));
        @(posedge clk); #1;

        // Shift amount source
        set_req(0, 32'h8000_0000, 32'd0, 5'd4, 4'd7, 1'b1);
        wait_grant(0);
        wait_rsp(0, 32'hF800_0000, 1'b0, "sra_shamt");
        set_req(0, 32'h8000_0000, 32'd1, 5'd4, 4'd7, 1'b0);
        wait_grant(0);
        wait_rsp(0, 32'hC000_0000, 1'b0, "sra_b");

        // Backpressure: owner stalls 5 cycles while requester 1 waits
        rsp_ready = '0;
        set_req(0, 32'd1, 32'd2, 5'd0, 4'd0, 1'b0);
        wait_grant(0);
        set_req(1, 32'd3, 32'd4, 5'd0, 4'd0, 1'b0);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid[0]) got = 1'b1;
        end
        check("bp_rsp_seen", 64'(got), 64'(1));
        for (int n = 0; n < 5; n++) begin
            if (n > 0) @(negedge clk);
            check("bp_ready", 64'(req_ready), 64'(0));
            check("bp_data", 64'(rsp_data), 64'(3));
            check("bp_valid", 64'(rsp_valid), 64'(2'b01));
        end
        @(posedge clk); #1;
        rsp_ready = 2'b01;
        @(negedge clk);
        check("bp_next_grant", 64'(req_ready), 64'(2'b10));
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        rsp_ready    = '1;
        wait_rsp(1, 32'd7, 1'b0, "bp_second");

        // Contention: both valid every cycle
        set_req(0, 32'd10, 32'd20, 5'd0, 4'd0, 1'b0);
        set_req(1, 32'd30, 32'd40, 5'd0, 4'd1, 1'b0);
        ng = 0;
        t  = 0;
        while (ng < 8 && t < 60) begin
            @(negedge clk);
            t++;
            if (req_ready != 0) begin
                gidx[ng] = req_ready[1] ? 1 : 0;
                gcyc[ng] = t;
                ng++;
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        check("cont_count", 64'(ng), 64'(8));
        for (int k = 1; k < ng; k++) begin
            check("cont_gap", 64'(gcyc[k] - gcyc[k-1]), 64'(2));
`ifdef ALU_ARB_FIXED_PRIO_EN
            check("cont_fixed", 64'(gidx[k]), 64'(0));
`else
            check("cont_alt", 64'(gidx[k]), 64'(1 - gidx[k-1]));
`endif
        end
        repeat (4) @(posedge clk);
        #1;

        // Reset while the op is in EXEC
        set_req(1, 32'd100, 32'd1, 5'd0, 4'd1, 1'b0);
        wait_grant(1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_exec_valid", 64'(rsp_valid), 64'(0));
        check("rst_exec_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(0, 32'd2, 32'd3, 5'd0, 4'd0, 1'b0);
        set_req(1, 32'd9, 32'd9, 5'd0, 4'd0, 1'b0);
        @(negedge clk);
        check("rst_first_grant", 64'(req_ready), 64'(2'b01));
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(0, 32'd5, 1'b0, "after_rst");

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g = req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                bit dropped;
                dropped = 1'b0;
                if (req_valid[i] && g[i]) begin
                    req_valid[i] = 1'b0;
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                    dropped      = 1'b1;
                end
                if (!req_valid[i] && !dropped && $urandom_range(0, 2) == 0)
                    set_req(i, rnd_val(), rnd_val(), 5'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
            end
        end
        req_valid = '0;
        rsp_ready = '1;
        repeat (6) @(negedge clk);
        check("drain_sb", 64'(sb.size()), 64'(0));
        check("drain_idle", 64'(busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
